// File: rtl/reg_bank_arb_pkg.sv
// Shared types and helpers for the round-robin register bank arbiter.
package reg_bank_arb_pkg;

  typedef enum logic {IDLE, LOCKED} state_t;

  // Index width for a requester count, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reference pick: first valid requester after ptr, -1 when none.
  function automatic int rr_pick(input logic [15:0] valid, input int ptr, input int n);
    for (int k = 1; k <= n; k++) begin
      if (valid[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_arb.sv
// Combinational round-robin picker; mask_en restricts the pick to mask_idx.
module rr_arb
  import reg_bank_arb_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int PW      = ptr_width(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] i_valid,
  input  logic [PW-1:0]      i_ptr,
  input  logic               i_mask_en,
  input  logic [PW-1:0]      i_mask_idx,
  output logic [REQ_NUM-1:0] o_gnt,
  output logic [PW-1:0]      o_idx
);

  logic [REQ_NUM-1:0] w_vm;
  logic               w_found;

  always_comb begin
    w_vm    = i_valid;
    if (i_mask_en) w_vm = i_valid & (REQ_NUM'(1) << i_mask_idx);
    w_found = 1'b0;
    o_idx   = '0;
    // Scan ptr+1, ptr+2, ... so the last winner gets lowest priority.
    for (int k = 1; k <= REQ_NUM; k++) begin
      if (!w_found && w_vm[(int'(i_ptr) + k) % REQ_NUM]) begin
        w_found = 1'b1;
        o_idx   = PW'((int'(i_ptr) + k) % REQ_NUM);
      end
    end
    o_gnt = w_found ? (REQ_NUM'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by REQ_NUM requesters: round-robin grant, optional
// lock for atomic sequences, watchdog-forced release, 1-cycle read latency.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int REQ_NUM    = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [REQ_NUM-1:0]               req_valid_i,
  output logic [REQ_NUM-1:0]               req_ready_o,
  input  logic [REQ_NUM-1:0]               req_we_i,
  input  logic [REQ_NUM-1:0]               req_lock_i,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]    req_wdat_i,
  output logic [REQ_NUM-1:0]               rsp_valid_o,
  output logic [DATA_WIDTH-1:0]            rsp_rdat_o,
  output logic                             lock_err_o
);

  localparam int PW    = ptr_width(REQ_NUM);
  localparam int CW    = $clog2(LOCK_MAX + 1);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  state_t                  r_state, w_state_nxt;
  logic [PW-1:0]           r_ptr, w_ptr_nxt;
  logic [PW-1:0]           r_owner, w_owner_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic                    r_err, w_err_nxt;
  logic [REQ_NUM-1:0]      r_rsp_vld;
  logic [DATA_WIDTH-1:0]   r_rdat;
  logic [DATA_WIDTH-1:0]   r_bank [DEPTH];

  logic [REQ_NUM-1:0]      w_gnt;
  logic [PW-1:0]           w_idx;
  logic                    w_fire, w_we, w_lock;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdat;

  rr_arb #(.REQ_NUM(REQ_NUM), .PW(PW)) u_arb (
    .i_valid    (req_valid_i),
    .i_ptr      (r_ptr),
    .i_mask_en  (r_state == LOCKED),
    .i_mask_idx (r_owner),
    .o_gnt      (w_gnt),
    .o_idx      (w_idx)
  );

  assign w_fire = (|w_gnt) & ~rst_i;
  assign w_we   = req_we_i[w_idx];
  assign w_lock = req_lock_i[w_idx];
  assign w_addr = req_addr_i[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdat = req_wdat_i[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Outputs are masked during reset so an in-flight read response is dropped.
  assign req_ready_o = rst_i ? '0 : w_gnt;
  assign rsp_valid_o = r_rsp_vld & {REQ_NUM{~rst_i}};
  assign rsp_rdat_o  = r_rdat;
  assign lock_err_o  = r_err & ~rst_i;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fire) begin
          w_ptr_nxt = w_idx;
          if (w_lock) begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_idx;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      LOCKED: begin
        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
        if (w_fire && !w_lock) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          // Watchdog: an owner fire this cycle is still honoured above.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_ptr     <= PW'(REQ_NUM - 1);
      r_owner   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rsp_vld <= '0;
      r_rdat    <= '0;
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err     <= w_err_nxt;
      r_rsp_vld <= (w_fire && !w_we) ? w_gnt : '0;
      if (w_fire && !w_we) r_rdat <= r_bank[w_addr];
      if (w_fire && w_we)  r_bank[w_addr] <= w_wdat;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench: stimulus pushes expected read responses, a monitor pops them.
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  v, we, lk;
  logic [2:0]  ad [4];
  logic [31:0] wd [4];
  logic [3:0]  req_ready_o, rsp_valid_o;
  logic [31:0] rsp_rdat_o;
  logic        lock_err_o;

  typedef struct { logic [3:0] m; logic [31:0] d; } exp_t;
  exp_t q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.REQ_NUM(4), .ADDR_WIDTH(3), .DATA_WIDTH(32), .LOCK_MAX(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (v),
    .req_ready_o (req_ready_o),
    .req_we_i    (we),
    .req_lock_i  (lk),
    .req_addr_i  ({ad[3], ad[2], ad[1], ad[0]}),
    .req_wdat_i  ({wd[3], wd[2], wd[1], wd[0]}),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdat_o  (rsp_rdat_o),
    .lock_err_o  (lock_err_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: check grant and lock_err, queue the read response if any.
  task automatic cyc(input logic [3:0] eg, input logic [31:0] erd, input logic eerr, input string name);
    exp_t e;
    @(negedge clk);
    chk({name, "_gnt"}, {28'd0, req_ready_o}, {28'd0, eg});
    chk({name, "_err"}, {31'd0, lock_err_o}, {31'd0, eerr});
    if ((eg & ~we) != 4'd0) begin
      e.m = eg;
      e.d = erd;
      q.push_back(e);
    end
    tick();
  endtask

  always @(negedge clk) begin
    if (rsp_valid_o != 4'd0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got valid=%b expected none at %0t", rsp_valid_o, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_mask", {28'd0, rsp_valid_o}, {28'd0, e.m});
        chk("rsp_rdat", rsp_rdat_o, e.d);
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    v = 4'b0001; we = '0; lk = '0;
    for (int i = 0; i < 4; i++) begin ad[i] = '0; wd[i] = '0; end
    @(negedge clk);
    chk("reset_ready", {28'd0, req_ready_o}, 32'd0);
    chk("reset_rspv", {28'd0, rsp_valid_o}, 32'd0);
    tick(); tick();
    rst_i = 1'b0; v = '0;
    @(negedge clk);
    chk("reset_rdat", rsp_rdat_o, 32'd0);
    chk("reset_err", {31'd0, lock_err_o}, 32'd0);
    tick();

    // All valid reads: rotation from requester 0.
    v = 4'b1111;
    for (int i = 0; i < 4; i++) ad[i] = 3'(i);
    for (int c = 0; c < 8; c++) cyc(4'b0001 << (c % 4), 32'd0, 1'b0, "rotate");

    // req0 sweeps all addresses of the cleared bank.
    v = 4'b0001;
    for (int a = 0; a < 8; a++) begin
      ad[0] = 3'(a);
      cyc(4'b0001, 32'd0, 1'b0, "sweep");
    end

    // Write then immediate read of the same address by another requester.
    v = 4'b0100; we[2] = 1'b1; ad[2] = 3'd5; wd[2] = 32'hDEADBEEF;
    cyc(4'b0100, 32'd0, 1'b0, "wr5");
    we[2] = 1'b0;
    v = 4'b0010; ad[1] = 3'd5;
    cyc(4'b0010, 32'hDEADBEEF, 1'b0, "rd5");

    // req1 lock sequence with competitors waiting.
    lk[1] = 1'b1;
    cyc(4'b0010, 32'hDEADBEEF, 1'b0, "lock_fire");
    v = 4'b1011; ad[0] = 3'd0; ad[3] = 3'd3;
    cyc(4'b0010, 32'hDEADBEEF, 1'b0, "lock_rd");
    v = 4'b1001;
    cyc(4'b0000, 32'd0, 1'b0, "lock_hold1");
    cyc(4'b0000, 32'd0, 1'b0, "lock_hold2");
    v = 4'b1011; we[1] = 1'b1; lk[1] = 1'b0; ad[1] = 3'd2; wd[1] = 32'h12345678;
    cyc(4'b0010, 32'd0, 1'b0, "lock_wr_rel");
    we[1] = 1'b0;
    v = 4'b1101; ad[2] = 3'd2;
    cyc(4'b0100, 32'h12345678, 1'b0, "post_rel_r2");
    v = 4'b1001;
    cyc(4'b1000, 32'd0, 1'b0, "post_rel_r3");
    v = 4'b0001;
    cyc(4'b0001, 32'd0, 1'b0, "post_rel_r0");

    // Watchdog: req0 locks then goes quiet while req1 waits.
    lk[0] = 1'b1; ad[0] = 3'd5;
    cyc(4'b0001, 32'hDEADBEEF, 1'b0, "wd_lock");
    lk[0] = 1'b0; v = 4'b0010; ad[1] = 3'd1;
    for (int c = 0; c < 16; c++) cyc(4'b0000, 32'd0, 1'b0, "wd_wait");
    cyc(4'b0010, 32'd0, 1'b1, "wd_release");
    v = '0;
    cyc(4'b0000, 32'd0, 1'b0, "wd_after");

    // Reset right after a read fire drops the response and clears the bank.
    v = 4'b1000; ad[3] = 3'd2;
    cyc(4'b1000, 32'h12345678, 1'b0, "pre_rst_rd");
    rst_i = 1'b1; v = 4'b0001; ad[0] = 3'd2;
    q.delete();
    @(negedge clk);
    chk("rst_drop_rspv", {28'd0, rsp_valid_o}, 32'd0);
    chk("rst_ready", {28'd0, req_ready_o}, 32'd0);
    tick();
    rst_i = 1'b0; v = '0;
    @(negedge clk);
    chk("rst_rdat_clr", rsp_rdat_o, 32'd0);
    tick();
    v = 4'b0001;
    cyc(4'b0001, 32'd0, 1'b0, "rd_after_rst");
    v = '0;
    cyc(4'b0000, 32'd0, 1'b0, "idle1");
    cyc(4'b0000, 32'd0, 1'b0, "idle2");
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
